// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches one instruction word per request from a
// variable-latency memory into the IR, and presents the decoded fields to the
// multicycle control unit. The control unit can overwrite the PC at any time.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch after MAX_WAIT cycles
// without an acknowledge and raise a sticky fetch_err flag.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int                MAX_WAIT = 15
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_write,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       ir,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    // The two low PC bits are forced to zero whenever a new value is loaded.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              mem_rd_q, mem_rd_d;
    logic              fetch_err_q, fetch_err_d;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Next-state logic: FSM transitions, PC update (pc_write beats the +4),
    // IR capture on ack, and optional timeout abort.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        mem_rd_d    = mem_rd_q;
        fetch_err_d = fetch_err_q;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_req) begin
                    state_d     = FETCH;
                    mem_rd_d    = 1'b1;
                    ir_valid_d  = 1'b0;
                    fetch_err_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_rd_d   = 1'b0;
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(4);
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt_q == LAST_WAIT) begin
                    state_d     = IDLE;
                    mem_rd_d    = 1'b0;
                    fetch_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
            end
        endcase
        if (pc_write) begin
            pc_d = pc_in & ALIGN_MASK;
        end
    end

    // State and output registers; reset aborts any in-flight fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC & ALIGN_MASK;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            mem_rd_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            mem_rd_q    <= mem_rd_d;
            fetch_err_q <= fetch_err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Cycles spent waiting in the current fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_rd   = mem_rd_q;
    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign busy     = (state_q == FETCH);
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm16    = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with hand-computed expected values.
module tb_instr_fetch_unit;

   logic        clock;
   logic        reset;
   logic        fetch_req;
   logic        pc_write;
   logic [31:0] pc_in;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic        ir_valid;
   logic        busy;
   logic        fetch_err;

   int vectorCount = 0;
   int missCount   = 0;

   instr_fetch_unit dut (
      .clock     (clock),
      .reset     (reset),
      .fetch_req (fetch_req),
      .pc_write  (pc_write),
      .pc_in     (pc_in),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .pc        (pc),
      .ir        (ir),
      .opcode    (opcode),
      .rs        (rs),
      .rt        (rt),
      .rd        (rd),
      .shamt     (shamt),
      .funct     (funct),
      .imm16     (imm16),
      .ir_valid  (ir_valid),
      .busy      (busy),
      .fetch_err (fetch_err)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value with its expected value and log any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance one clock and settle just past the rising edge, where inputs
   // are driven and outputs sampled.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   // Issue a fetch request and leave the DUT in its first FETCH cycle.
   task automatic startFetch();
      fetch_req = 1'b1;
      applyStimulus();
      fetch_req = 1'b0;
   endtask

   // Acknowledge the current FETCH cycle with the given data.
   task automatic ackWith(input logic [31:0] data);
      mem_ack   = 1'b1;
      mem_rdata = data;
      applyStimulus();
      mem_ack   = 1'b0;
   endtask

   int rdHigh;

   initial begin
      reset     = 1'b1;
      fetch_req = 1'b0;
      pc_write  = 1'b0;
      pc_in     = '0;
      mem_rdata = '0;
      mem_ack   = 1'b0;
      repeat (2) @(posedge clock);
      #3 reset = 1'b0;
      applyStimulus();

      // Reset state
      checkOutput("reset_pc",       pc,        32'h0);
      checkOutput("reset_ir",       ir,        32'h0);
      checkOutput("reset_ir_valid", ir_valid,  32'h0);
      checkOutput("reset_mem_rd",   mem_rd,    32'h0);
      checkOutput("reset_busy",     busy,      32'h0);
      checkOutput("reset_fetch_err",fetch_err, 32'h0);

      // Fastest fetch: ack in the first FETCH cycle, R-type word
      startFetch();
      checkOutput("t1_mem_rd",   mem_rd,   32'h1);
      checkOutput("t1_busy",     busy,     32'h1);
      checkOutput("t1_mem_addr", mem_addr, 32'h0);
      ackWith(32'h012A4020);
      checkOutput("t1_ir_valid", ir_valid, 32'h1);
      checkOutput("t1_opcode",   opcode,   32'h0);
      checkOutput("t1_rs",       rs,       32'd9);
      checkOutput("t1_rt",       rt,       32'd10);
      checkOutput("t1_rd",       rd,       32'd8);
      checkOutput("t1_shamt",    shamt,    32'h0);
      checkOutput("t1_funct",    funct,    32'h20);
      checkOutput("t1_pc",       pc,       32'h4);
      checkOutput("t1_mem_rd_off", mem_rd, 32'h0);

      // Five wait cycles, then ack: mem_rd high for six cycles at a stable address
      startFetch();
      checkOutput("t2_ir_valid_cleared", ir_valid, 32'h0);
      rdHigh = 0;
      for (int i = 0; i < 5; i++) begin
         if (mem_rd === 1'b1) rdHigh++;
         checkOutput("t2_mem_addr_wait", mem_addr, 32'h4);
         applyStimulus();
      end
      if (mem_rd === 1'b1) rdHigh++;
      checkOutput("t2_mem_addr_ack", mem_addr, 32'h4);
      ackWith(32'h8C220008);
      checkOutput("t2_mem_rd_cycles", rdHigh, 32'd6);
      checkOutput("t2_mem_rd_off", mem_rd, 32'h0);
      checkOutput("t2_opcode",   opcode,   32'h23);
      checkOutput("t2_rs",       rs,       32'd1);
      checkOutput("t2_rt",       rt,       32'd2);
      checkOutput("t2_imm16",    imm16,    32'h8);
      checkOutput("t2_pc",       pc,       32'h8);

      // pc_write together with ack: IR loads, PC takes aligned pc_in, no +4
      startFetch();
      pc_write = 1'b1;
      pc_in    = 32'h103;
      ackWith(32'hDEADBEEF);
      pc_write = 1'b0;
      checkOutput("t3_ir",       ir,       32'hDEADBEEF);
      checkOutput("t3_ir_valid", ir_valid, 32'h1);
      checkOutput("t3_pc",       pc,       32'h100);

      // Ack while idle is ignored
      mem_ack   = 1'b1;
      mem_rdata = 32'h11111111;
      applyStimulus();
      mem_ack   = 1'b0;
      checkOutput("idle_ack_ir",     ir,     32'hDEADBEEF);
      checkOutput("idle_ack_pc",     pc,     32'h100);
      checkOutput("idle_ack_mem_rd", mem_rd, 32'h0);

      // pc_write mid-FETCH retargets mem_addr from the next cycle
      startFetch();
      pc_write = 1'b1;
      pc_in    = 32'h41;
      applyStimulus();
      pc_write = 1'b0;
      checkOutput("t3b_mem_addr", mem_addr, 32'h40);
      checkOutput("t3b_busy",     busy,     32'h1);
      ackWith(32'h00000000);
      checkOutput("t3b_pc",       pc,       32'h44);

      // PC wraps silently from the top aligned address
      pc_write = 1'b1;
      pc_in    = 32'hFFFFFFFC;
      applyStimulus();
      pc_write = 1'b0;
      checkOutput("t4_pc_load", pc, 32'hFFFFFFFC);
      startFetch();
      checkOutput("t4_mem_addr", mem_addr, 32'hFFFFFFFC);
      ackWith(32'h20010005);
      checkOutput("t4_pc_wrap", pc,    32'h0);
      checkOutput("t4_imm16",   imm16, 32'h5);

      // Fetch that never acks within MAX_WAIT=15 cycles
      startFetch();
      for (int i = 0; i < 15; i++) begin
         checkOutput("t6_busy_waiting", busy, 32'h1);
         applyStimulus();
      end
`ifdef FETCH_TIMEOUT_EN
      checkOutput("t6_fetch_err", fetch_err, 32'h1);
      checkOutput("t6_busy_off",  busy,      32'h0);
      checkOutput("t6_mem_rd",    mem_rd,    32'h0);
      checkOutput("t6_pc",        pc,        32'h0);
      checkOutput("t6_ir",        ir,        32'h20010005);
      checkOutput("t6_ir_valid",  ir_valid,  32'h0);
      startFetch();
      checkOutput("t6_err_clear", fetch_err, 32'h0);
      ackWith(32'h00000000);
`else
      checkOutput("t6_still_busy", busy,      32'h1);
      checkOutput("t6_no_err",     fetch_err, 32'h0);
      ackWith(32'h00000000);
`endif
      checkOutput("t6_done_pc", pc, 32'h4);

      // Reset in mid-FETCH; a late ack afterwards is ignored
      startFetch();
      applyStimulus();
      reset = 1'b1;
      #2;
      checkOutput("t5_mem_rd",   mem_rd,   32'h0);
      checkOutput("t5_busy",     busy,     32'h0);
      checkOutput("t5_pc",       pc,       32'h0);
      checkOutput("t5_ir",       ir,       32'h0);
      checkOutput("t5_ir_valid", ir_valid, 32'h0);
      #2 reset = 1'b0;
      ackWith(32'hCAFEF00D);
      checkOutput("t5_late_ir",     ir,       32'h0);
      checkOutput("t5_late_valid",  ir_valid, 32'h0);
      checkOutput("t5_late_pc",     pc,       32'h0);
      checkOutput("t5_late_mem_rd", mem_rd,   32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
